// File: rtl/arc4_ksa_if.sv
// arc4_ksa_if: rdy/en handshake, key and single-port S-memory signals for arc4_ksa
interface arc4_ksa_if #(parameter int ADDR_W = 8, parameter int DATA_W = ADDR_W, parameter int KEY_BYTES = 3);
  logic en;
  logic rdy;
  logic [KEY_BYTES*DATA_W-1:0] key;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic wren;
  logic [DATA_W-1:0] rddata;
  modport master (input en, key, rddata, output rdy, addr, wrdata, wren);
  modport slave (output en, key, rddata, input rdy, addr, wrdata, wren);
endinterface

// File: rtl/arc4_ksa.sv
// arc4_ksa: ARC4 S-array init and key schedule over a single-port synchronous S-memory.
// Define ARC4_KSA_INIT_EN to include the s[i]=i init phase; otherwise the memory must be preloaded.
module arc4_ksa #(parameter int ADDR_W = 8, parameter int DATA_W = ADDR_W, parameter int KEY_BYTES = 3) (
  input logic clk,
  input logic rst_n,
  arc4_ksa_if.master bus
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);
  typedef enum logic [2:0] {IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J} state_t;
`ifdef ARC4_KSA_INIT_EN
  localparam state_t START = INIT;
`else
  localparam state_t START = KSA_RD_I;
`endif
  state_t state;
  logic [ADDR_W-1:0] i, j, jn;
  logic [DATA_W-1:0] si;
  logic [KW-1:0] k;
  logic [KEY_BYTES*DATA_W-1:0] key_r;
  logic [DATA_W-1:0] unit [KEY_BYTES];
  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_unit
    assign unit[g] = key_r[(KEY_BYTES-1-g)*DATA_W +: DATA_W];
  end
  // rddata holds s[i] in KSA_RD_J, so the j address is formed in the same cycle
  assign jn = j + bus.rddata + unit[k];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      si <= '0;
      key_r <= '0;
    end else
      case (state)
        IDLE: if (bus.en) begin
          key_r <= bus.key;
          i <= '0;
          j <= '0;
          k <= '0;
          state <= START;
        end
`ifdef ARC4_KSA_INIT_EN
        INIT: begin
          i <= i + 1'b1;
          state <= i == LAST ? KSA_RD_I : INIT;
        end
`endif
        KSA_RD_I: state <= KSA_RD_J;
        KSA_RD_J: begin
          si <= bus.rddata;
          j <= jn;
          state <= KSA_WR_I;
        end
        KSA_WR_I: state <= KSA_WR_J;
        KSA_WR_J: begin
          i <= i + 1'b1;
          k <= k == K_LAST ? '0 : k + 1'b1;
          state <= i == LAST ? IDLE : KSA_RD_I;
        end
        default: state <= IDLE;
      endcase
  always_comb begin
    bus.rdy = state == IDLE;
    bus.wren = state == INIT || state == KSA_WR_I || state == KSA_WR_J;
    bus.addr = state == KSA_RD_J ? jn : state == KSA_WR_J ? j : i;
    bus.wrdata = state == INIT ? i : state == KSA_WR_I ? bus.rddata : state == KSA_WR_J ? si : '0;
  end
endmodule

// File: tb/tb_arc4_ksa.sv
// tb_arc4_ksa: directed checks of arc4_ksa at ADDR_W=8/KEY_BYTES=3 and ADDR_W=2/KEY_BYTES=1,
// each DUT driving its own behavioural synchronous single-port S-memory.
module tb_arc4_ksa;
`ifdef ARC4_KSA_INIT_EN
  localparam int OFF8 = 256, OFF2 = 4;
`else
  localparam int OFF8 = 0, OFF2 = 0;
`endif
  localparam int LAT8 = OFF8 + 1024, LAT2 = OFF2 + 16;
  logic clk = 0, rst_n = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  arc4_ksa_if #(.ADDR_W(8), .DATA_W(8), .KEY_BYTES(3)) bus8 ();
  arc4_ksa_if #(.ADDR_W(2), .DATA_W(2), .KEY_BYTES(1)) bus2 ();
  arc4_ksa #(.ADDR_W(8), .DATA_W(8), .KEY_BYTES(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  arc4_ksa #(.ADDR_W(2), .DATA_W(2), .KEY_BYTES(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  logic [7:0] mem8 [256];
  logic [1:0] mem2 [4];
  logic [7:0] exp8 [256];
  logic [7:0] snap2 [4];
  bit fill8 = 0, fill2 = 0;
  logic [7:0] fill8_x = 0;
  always @(posedge clk)
    if (fill8) for (int n = 0; n < 256; n++) mem8[n] <= 8'(n) ^ fill8_x;
    else begin
      if (bus8.wren) mem8[bus8.addr] <= bus8.wrdata;
      bus8.rddata <= mem8[bus8.addr];
    end
  always @(posedge clk)
    if (fill2) for (int n = 0; n < 4; n++) mem2[n] <= 2'(n);
    else begin
      if (bus2.wren) mem2[bus2.addr] <= bus2.wrdata;
      bus2.rddata <= mem2[bus2.addr];
    end
  typedef struct { logic [1:0] key; logic [7:0] exp; } vec_t;
  vec_t vt [4];
  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] pk2();
    return {mem2[3], mem2[2], mem2[1], mem2[0]};
  endfunction
  function automatic void model8(input logic [23:0] k);
    logic [7:0] jj, t;
    for (int n = 0; n < 256; n++) exp8[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + exp8[n] + k[8*(2 - n % 3) +: 8];
      t = exp8[n];
      exp8[n] = exp8[jj];
      exp8[jj] = t;
    end
  endfunction
  task automatic cmp_big(input string nm);
    int bad = 0;
    for (int n = 0; n < 256; n++) if (mem8[n] !== exp8[n]) bad++;
    check(nm, bad, 0);
  endtask
  task automatic fill_big(input logic [7:0] x);
    @(negedge clk) fill8_x = x;
    fill8 = 1;
    @(posedge clk) #1 fill8 = 0;
  endtask
  task automatic fill_small();
    @(negedge clk) fill2 = 1;
    @(posedge clk) #1 fill2 = 0;
  endtask
  task automatic run_big(input logic [23:0] k, input bit poke, output int cyc);
    int bad;
    @(negedge clk) bus8.key = k;
    bus8.en = 1;
    @(posedge clk) #1 bus8.en = 0;
    bus8.key = 24'hA5A5A5;
    cyc = 0;
    while (cyc < 2 * LAT8) begin
      @(posedge clk) #1 cyc++;
      bus8.en = poke && cyc == OFF8 + 600;
      if (bus8.rdy) break;
`ifdef ARC4_KSA_INIT_EN
      if (cyc == OFF8) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem8[n] !== 8'(n)) bad++;
        check("init_identity_bad_entries", bad, 0);
      end
`endif
    end
    bus8.en = 0;
  endtask
  task automatic run_small(input logic [1:0] k, output int cyc);
    int idx;
    fill_small();
    @(negedge clk) bus2.key = k;
    bus2.en = 1;
    @(posedge clk) #1 bus2.en = 0;
    bus2.key = ~k;
    cyc = 0;
    while (cyc < 2 * LAT2) begin
      @(posedge clk) #1 cyc++;
      idx = (cyc - OFF2) / 4 - 1;
      if (cyc > OFF2 && (cyc - OFF2) % 4 == 0 && idx < 4) snap2[idx] = pk2();
      if (bus2.rdy) break;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    vt[0] = '{2'd0, {2'd1, 2'd3, 2'd2, 2'd0}};
    vt[1] = '{2'd1, {2'd1, 2'd3, 2'd2, 2'd0}};
    vt[2] = '{2'd2, {2'd1, 2'd3, 2'd0, 2'd2}};
    vt[3] = '{2'd3, {2'd2, 2'd3, 2'd0, 2'd1}};
    bus8.en = 0;
    bus8.key = 0;
    bus2.en = 0;
    bus2.key = 0;
    repeat (3) @(posedge clk);
    #1 check("rst_rdy8", bus8.rdy, 1);
    check("rst_wren8", bus8.wren, 0);
    check("rst_addr8", bus8.addr, 0);
    check("rst_wrdata8", bus8.wrdata, 0);
    check("rst_rdy2", bus2.rdy, 1);
    check("rst_wren2", bus2.wren, 0);
    check("rst_addr2", bus2.addr, 0);
    check("rst_wrdata2", bus2.wrdata, 0);
    @(negedge clk) rst_n = 1;
`ifdef ARC4_KSA_INIT_EN
    fill_big(8'hFF);
`else
    fill_big(8'h00);
`endif
    model8(24'h00033C);
    run_big(24'h00033C, 0, cyc);
    check("lat8_key00033c", cyc, LAT8);
    cmp_big("ksa8_key00033c_bad_entries");
    for (int v = 0; v < 4; v++) begin
      run_small(vt[v].key, cyc);
      check($sformatf("lat2_key%0d", vt[v].key), cyc, LAT2);
      check($sformatf("mem2_key%0d", vt[v].key), pk2(), vt[v].exp);
    end
    run_small(2'd1, cyc);
    check("swap0_key1", snap2[0], {2'd3, 2'd2, 2'd0, 2'd1});
    check("swap1_key1", snap2[1], {2'd3, 2'd0, 2'd2, 2'd1});
    check("swap2_key1", snap2[2], {2'd0, 2'd3, 2'd2, 2'd1});
    check("swap3_key1", snap2[3], {2'd1, 2'd3, 2'd2, 2'd0});
    fill_big(8'h00);
    model8(24'hC0FFEE);
    run_big(24'hC0FFEE, 1, cyc);
    check("lat8_en_poke", cyc, LAT8);
    cmp_big("ksa8_en_poke_bad_entries");
    fill_big(8'h00);
    @(negedge clk) bus8.key = 24'h123456;
    bus8.en = 1;
    @(posedge clk) #1 bus8.en = 0;
    repeat (OFF8 + 703) @(posedge clk);
    #1 check("pre_abort_wren", bus8.wren, 1);
    #2 rst_n = 0;
    #1 check("abort_wren", bus8.wren, 0);
    check("abort_rdy", bus8.rdy, 1);
    check("abort_addr", bus8.addr, 0);
    @(negedge clk) rst_n = 1;
    fill_big(8'h00);
    model8(24'h0A0B0C);
    run_big(24'h0A0B0C, 0, cyc);
    check("lat8_after_abort", cyc, LAT8);
    cmp_big("ksa8_after_abort_bad_entries");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
